// File: rtl/div_unit_rv_if.sv
// ============================================================================
// Module      : div_unit_rv_if
// Description : Request/response bundle between the execute stage and the
//               iterative divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_unit_rv_if #(
    parameter int DW = 32
);
    logic          start_i;
    logic [1:0]    op_i;
    logic [DW-1:0] dividend_i;
    logic [DW-1:0] divisor_i;
    logic          flush_i;
    logic [DW-1:0] result_o;
    logic          valid_o;
    logic          busy_o;

    modport master (
        output start_i, op_i, dividend_i, divisor_i, flush_i,
        input  result_o, valid_o, busy_o
    );

    modport slave (
        input  start_i, op_i, dividend_i, divisor_i, flush_i,
        output result_o, valid_o, busy_o
    );
endinterface

`default_nettype wire

// File: rtl/div_unit_rv.sv
// ============================================================================
// Module      : div_unit_rv
// Description : Iterative restoring divider for RV32M/RV64M DIV/DIVU/REM/REMU
//               with flush and a one-entry quotient/remainder cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit_rv #(
    parameter int DW = 32,
    parameter int CW = $clog2(DW + 1)
) (
    input  wire logic     clk,
    input  wire logic     rst,
    div_unit_rv_if.slave  bus
);

    localparam logic [DW-1:0] c_MIN_NEG = {1'b1, {(DW-1){1'b0}}};
    localparam logic [CW-1:0] c_LAST    = CW'(DW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;

    logic [1:0]    r_op;
    logic          r_signed;
    logic          r_qsign;
    logic          r_rsign;
    logic          r_fixed;
    logic [DW-1:0] r_dvd;
    logic [DW-1:0] r_dvs;
    logic [DW-1:0] r_dvs_mag;
    logic [DW-1:0] r_quo;
    logic [DW:0]   r_rem;
    logic [DW-1:0] r_hold;

    logic          r_c_valid;
    logic          r_c_signed;
    logic [DW-1:0] r_c_dvd;
    logic [DW-1:0] r_c_dvs;
    logic [DW-1:0] r_c_quo;
    logic [DW-1:0] r_c_rem;

    logic          w_in_signed;
    logic          w_dvd_neg;
    logic          w_dvs_neg;
    logic [DW-1:0] w_dvd_mag;
    logic [DW-1:0] w_dvs_mag;
    logic          w_div_zero;
    logic          w_ovf;
    logic          w_hit_done;
    logic          w_hit_cache;
    logic          w_hit;
    logic          w_accept;
    logic          w_fast;
    logic [DW-1:0] w_hit_quo;
    logic [DW-1:0] w_hit_rem;
    logic [DW+1:0] w_diff;
    logic [DW-1:0] w_q_final;
    logic [DW-1:0] w_r_final;
    logic [DW-1:0] w_result;

    // ------------------------------------------------------------------------
    // Operand decode and fast-path detection
    // ------------------------------------------------------------------------
    assign w_in_signed = ~bus.op_i[0];
    assign w_dvd_neg   = w_in_signed & bus.dividend_i[DW-1];
    assign w_dvs_neg   = w_in_signed & bus.divisor_i[DW-1];
    assign w_dvd_mag   = w_dvd_neg ? (~bus.dividend_i + 1'b1) : bus.dividend_i;
    assign w_dvs_mag   = w_dvs_neg ? (~bus.divisor_i + 1'b1) : bus.divisor_i;
    assign w_div_zero  = (bus.divisor_i == '0);
    assign w_ovf       = w_in_signed && (bus.dividend_i == c_MIN_NEG) && (bus.divisor_i == '1);

    // The result being presented this cycle counts as a hit before it reaches the cache.
    assign w_hit_done  = (r_state == S_DONE) && (r_dvd == bus.dividend_i) &&
                         (r_dvs == bus.divisor_i) && (r_signed == w_in_signed);
    assign w_hit_cache = r_c_valid && (r_c_dvd == bus.dividend_i) &&
                         (r_c_dvs == bus.divisor_i) && (r_c_signed == w_in_signed);
    assign w_hit       = w_hit_done | w_hit_cache;
    assign w_hit_quo   = w_hit_done ? w_q_final : r_c_quo;
    assign w_hit_rem   = w_hit_done ? w_r_final : r_c_rem;

    assign w_accept    = bus.start_i & ~bus.flush_i & (r_state != S_CALC);
    assign w_fast      = w_div_zero | w_ovf | w_hit;

    // One restoring step: shift in the next dividend bit and trial-subtract.
    assign w_diff      = {r_rem, r_quo[DW-1]} - {2'b00, r_dvs_mag};

    assign w_q_final   = (!r_fixed && r_qsign) ? (~r_quo + 1'b1) : r_quo;
    assign w_r_final   = (!r_fixed && r_rsign) ? (~r_rem[DW-1:0] + 1'b1) : r_rem[DW-1:0];
    assign w_result    = r_op[1] ? w_r_final : w_q_final;

    assign bus.result_o = (r_state == S_DONE) ? w_result : r_hold;
    assign bus.valid_o  = (r_state == S_DONE) & ~bus.flush_i;
    assign bus.busy_o   = (r_state == S_CALC);

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (bus.flush_i) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept) w_next = w_fast ? S_DONE : S_CALC;
                S_CALC:  if (r_cnt == c_LAST) w_next = S_DONE;
                S_DONE:  w_next = w_accept ? (w_fast ? S_DONE : S_CALC) : S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Datapath and operand cache
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_op       <= '0;
            r_signed   <= 1'b0;
            r_qsign    <= 1'b0;
            r_rsign    <= 1'b0;
            r_fixed    <= 1'b0;
            r_dvd      <= '0;
            r_dvs      <= '0;
            r_dvs_mag  <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_hold     <= '0;
            r_c_valid  <= 1'b0;
            r_c_signed <= 1'b0;
            r_c_dvd    <= '0;
            r_c_dvs    <= '0;
            r_c_quo    <= '0;
            r_c_rem    <= '0;
        end else begin
            if (r_state == S_DONE) begin
                r_hold <= w_result;
            end

            if (bus.flush_i) begin
                r_c_valid <= 1'b0;
            end else if (r_state == S_DONE) begin
                r_c_valid  <= 1'b1;
                r_c_signed <= r_signed;
                r_c_dvd    <= r_dvd;
                r_c_dvs    <= r_dvs;
                r_c_quo    <= w_q_final;
                r_c_rem    <= w_r_final;
            end

            if (bus.flush_i) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt     <= '0;
                r_op      <= bus.op_i;
                r_signed  <= w_in_signed;
                r_qsign   <= w_dvd_neg ^ w_dvs_neg;
                r_rsign   <= w_dvd_neg;
                r_dvd     <= bus.dividend_i;
                r_dvs     <= bus.divisor_i;
                r_dvs_mag <= w_dvs_mag;
                if (w_div_zero) begin
                    r_quo   <= '1;
                    r_rem   <= {1'b0, bus.dividend_i};
                    r_fixed <= 1'b1;
                end else if (w_ovf) begin
                    r_quo   <= bus.dividend_i;
                    r_rem   <= '0;
                    r_fixed <= 1'b1;
                end else if (w_hit) begin
                    r_quo   <= w_hit_quo;
                    r_rem   <= {1'b0, w_hit_rem};
                    r_fixed <= 1'b1;
                end else begin
                    r_quo   <= w_dvd_mag;
                    r_rem   <= '0;
                    r_fixed <= 1'b0;
                end
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt + CW'(1);
                if (!w_diff[DW+1]) begin
                    r_rem <= w_diff[DW:0];
                    r_quo <= {r_quo[DW-2:0], 1'b1};
                end else begin
                    r_rem <= {r_rem[DW-1:0], r_quo[DW-1]};
                    r_quo <= {r_quo[DW-2:0], 1'b0};
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_unit_rv.sv
// ============================================================================
// Module      : tb_div_unit_rv
// Description : Scoreboard bench for div_unit_rv (DW=32).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_unit_rv;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_unit_rv_if #(.DW(DW)) bus ();

    div_unit_rv #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] scoreboard[$];

    function automatic logic [DW-1:0] model(input logic [1:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        logic signed [DW-1:0] sa, sd;
        logic [DW-1:0]        q, r;
        sa = a;
        sd = b;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = '0;
        end else if (!op[0]) begin
            q = sa / sd;
            r = sa % sd;
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    // Called at a negedge; returns at the negedge of cycle 1.
    task automatic drive_start(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.start_i    = 1'b1;
        bus.op_i       = op;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        scoreboard.push_back(model(op, a, b));
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bcnt, output logic [DW-1:0] res,
                             output bit got);
        lat  = 0;
        bcnt = 0;
        res  = '0;
        got  = 1'b0;
        for (int cyc = 1; cyc <= DW + 8; cyc++) begin
            if (bus.busy_o) bcnt++;
            if (bus.valid_o) begin
                got = 1'b1;
                lat = cyc;
                res = bus.result_o;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.result_o !== '0 || bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset: result=%h valid=%b busy=%b expected 0/0/0",
                     bus.result_o, bus.valid_o, bus.busy_o);
        end
    endtask

    task automatic test_divu_latency();
        int lat, bcnt; logic [DW-1:0] res, exp; bit got;
        drive_start(2'b01, 32'd100, 32'd7);
        wait_done(lat, bcnt, res, got);
        exp = scoreboard.pop_front();
        checks++;
        if (lat !== DW + 1) begin failures++; $display("FAIL divu_latency: got %0d expected %0d", lat, DW + 1); end
        checks++;
        if (bcnt !== DW) begin failures++; $display("FAIL divu_busy: got %0d expected %0d", bcnt, DW); end
        checks++;
        if (res !== exp) begin failures++; $display("FAIL divu_result: got %h expected %h", res, exp); end
        @(negedge clk);
        checks++;
        if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL divu_valid_pulse: got %b expected 0", bus.valid_o); end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt; logic [DW-1:0] res, exp; bit got;
        drive_start(2'b00, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bcnt, res, got);
        exp = scoreboard.pop_front();
        checks++;
        if (lat !== DW + 1) begin failures++; $display("FAIL div_signed_latency: got %0d expected %0d", lat, DW + 1); end
        checks++;
        if (res !== exp) begin failures++; $display("FAIL div_signed_result: got %h expected %h", res, exp); end
        // REM on the same operands, issued while the DIV is still in DONE
        drive_start(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bcnt, res, got);
        exp = scoreboard.pop_front();
        checks++;
        if (lat !== 1 || bcnt !== 0) begin failures++; $display("FAIL rem_cache_hit: latency %0d busy %0d expected 1/0", lat, bcnt); end
        checks++;
        if (res !== exp) begin failures++; $display("FAIL rem_cache_result: got %h expected %h", res, exp); end
    endtask

    task automatic test_special(input string name, input logic [1:0] op, input logic [DW-1:0] a,
                                input logic [DW-1:0] b);
        int lat, bcnt; logic [DW-1:0] res, exp; bit got;
        drive_start(op, a, b);
        wait_done(lat, bcnt, res, got);
        exp = scoreboard.pop_front();
        checks++;
        if (lat !== 1 || bcnt !== 0) begin failures++; $display("FAIL %s_latency: latency %0d busy %0d expected 1/0", name, lat, bcnt); end
        checks++;
        if (res !== exp) begin failures++; $display("FAIL %s_result: got %h expected %h", name, res, exp); end
    endtask

    task automatic test_flush();
        int lat, bcnt, nvalid; logic [DW-1:0] res, exp; bit got;
        drive_start(2'b00, 32'd1000, 32'd3);
        wait_done(lat, bcnt, res, got);
        exp = scoreboard.pop_front();
        checks++;
        if (res !== exp) begin failures++; $display("FAIL flush_prefill: got %h expected %h", res, exp); end
        @(negedge clk);
        drive_start(2'b00, 32'd1000, 32'd7);
        void'(scoreboard.pop_front());
        repeat (9) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL flush_idle: busy got %b expected 0", bus.busy_o); end
        nvalid = 0;
        repeat (DW + 4) begin
            if (bus.valid_o) nvalid++;
            @(negedge clk);
        end
        checks++;
        if (nvalid !== 0) begin failures++; $display("FAIL flush_no_valid: got %0d pulses expected 0", nvalid); end
        // Cache was cleared, so this must take the full iterative path
        drive_start(2'b10, 32'd1000, 32'd3);
        wait_done(lat, bcnt, res, got);
        exp = scoreboard.pop_front();
        checks++;
        if (lat !== DW + 1) begin failures++; $display("FAIL flush_cache_cleared: latency %0d expected %0d", lat, DW + 1); end
        checks++;
        if (res !== exp) begin failures++; $display("FAIL flush_rem_result: got %h expected %h", res, exp); end
        @(negedge clk);
        // Flush during DONE suppresses the pulse
        drive_start(2'b01, 32'd9, 32'd0);
        void'(scoreboard.pop_front());
        bus.flush_i = 1'b1;
        #1;
        checks++;
        if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL flush_in_done: valid got %b expected 0", bus.valid_o); end
        @(negedge clk);
        bus.flush_i = 1'b0;
    endtask

    task automatic test_busy_ignore();
        int lat, bcnt, nvalid; logic [DW-1:0] res, exp; bit got;
        drive_start(2'b01, 32'd12345, 32'd67);
        repeat (4) @(negedge clk);
        bus.start_i    = 1'b1;
        bus.op_i       = 2'b10;
        bus.dividend_i = 32'd99;
        bus.divisor_i  = 32'd5;
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_done(lat, bcnt, res, got);
        exp = scoreboard.pop_front();
        checks++;
        if (!got || res !== exp) begin failures++; $display("FAIL busy_ignore_result: got %h (valid %b) expected %h", res, got, exp); end
        @(negedge clk);
        nvalid = 0;
        repeat (DW + 4) begin
            if (bus.valid_o) nvalid++;
            @(negedge clk);
        end
        checks++;
        if (nvalid !== 0) begin failures++; $display("FAIL busy_ignore_extra: got %0d pulses expected 0", nvalid); end
    endtask

    task automatic test_async_reset();
        drive_start(2'b01, 32'd777777, 32'd13);
        void'(scoreboard.pop_front());
        repeat (14) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.result_o !== '0) begin
            failures++;
            $display("FAIL async_reset: busy=%b valid=%b result=%h expected 0/0/0",
                     bus.busy_o, bus.valid_o, bus.result_o);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat, bcnt; logic [DW-1:0] res, exp, a, b; logic [1:0] op; bit got;
        for (int i = 0; i < 16; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case (i % 4)
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 9));
                2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: b = $urandom;
            endcase
            drive_start(op, a, b);
            wait_done(lat, bcnt, res, got);
            exp = scoreboard.pop_front();
            checks++;
            if (!got || res !== exp) begin
                failures++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, res, exp);
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.start_i    = 1'b0;
        bus.op_i       = 2'b00;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        bus.flush_i    = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_divu_latency();
        test_back_to_back();
        test_special("divu_zero", 2'b01, 32'd5, 32'd0);
        test_special("rem_zero", 2'b10, 32'h8000_0000, 32'd0);
        test_special("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        test_special("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        @(negedge clk);
        test_flush();
        test_busy_ignore();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
